// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined MIPS control unit.
// Decodes the IF/ID instruction, carries its controls through ID/EX, EX/MEM
// and MEM/WB, and raises stall/flush for load-use, RAW, branch and jump events.
// Build option: define FORWARD_EN to include EX operand forwarding. Without it,
// every RAW dependency on EX or MEM stalls and fwd_a/fwd_b stay at 00.
module pipe_ctrl_unit #(
    parameter int ALUCTRL_W = 4,
    parameter int REG_AW    = 5,
    parameter int LINK_REG  = 31
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [5:0]           id_opcode,
    input  logic [5:0]           id_func,
    input  logic [REG_AW-1:0]    id_rs,
    input  logic [REG_AW-1:0]    id_rt,
    input  logic [REG_AW-1:0]    id_rd,
    input  logic                 ex_branch_taken,
    output logic                 stall,
    output logic                 flush,
    output logic                 id_jump,
    output logic                 id_illegal,
    output logic [ALUCTRL_W-1:0] ex_alu_ctrl,
    output logic                 ex_alu_src,
    output logic                 ex_shift,
    output logic                 ex_branch,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 wb_reg_write,
    output logic                 wb_mem_to_reg,
    output logic [REG_AW-1:0]    wb_dst,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b
);

    // Decoded ID-stage controls
    logic [ALUCTRL_W-1:0] dec_alu_ctrl;
    logic                 dec_alu_src, dec_shift, dec_branch;
    logic                 dec_mem_read, dec_mem_write, dec_reg_write, dec_mem_to_reg;
    logic [REG_AW-1:0]    dec_dst;
    logic                 dec_jump, dec_illegal, rs_used, rt_used;

    // ID/EX stage register
    logic                 idex_valid_reg, idex_alu_src_reg, idex_shift_reg, idex_branch_reg;
    logic                 idex_mem_read_reg, idex_mem_write_reg, idex_reg_write_reg, idex_mem_to_reg_reg;
    logic [ALUCTRL_W-1:0] idex_alu_ctrl_reg;
    logic [REG_AW-1:0]    idex_dst_reg;

    // EX/MEM stage register
    logic                 exmem_valid_reg, exmem_mem_read_reg, exmem_mem_write_reg;
    logic                 exmem_reg_write_reg, exmem_mem_to_reg_reg;
    logic [REG_AW-1:0]    exmem_dst_reg;

    // MEM/WB stage register
    logic                 memwb_valid_reg, memwb_reg_write_reg, memwb_mem_to_reg_reg;
    logic [REG_AW-1:0]    memwb_dst_reg;

    logic idex_wr, exmem_wr, raw_stall;

    // Instruction decode; unknown encodings and idle slots produce all-zero controls
    always_comb begin
        dec_alu_ctrl   = '0;
        dec_alu_src    = 1'b0;
        dec_shift      = 1'b0;
        dec_branch     = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_dst        = '0;
        dec_jump       = 1'b0;
        dec_illegal    = 1'b0;
        rs_used        = 1'b0;
        rt_used        = 1'b0;
        if (id_valid) begin
            case (id_opcode)
                6'd0: begin
                    dec_reg_write = 1'b1;
                    dec_dst       = id_rd;
                    rs_used       = 1'b1;
                    rt_used       = 1'b1;
                    case (id_func)
                        6'd32: dec_alu_ctrl = ALUCTRL_W'(0);
                        6'd34: dec_alu_ctrl = ALUCTRL_W'(1);
                        6'd36: dec_alu_ctrl = ALUCTRL_W'(2);
                        6'd37: dec_alu_ctrl = ALUCTRL_W'(3);
                        6'd42: dec_alu_ctrl = ALUCTRL_W'(4);
                        6'd38: dec_alu_ctrl = ALUCTRL_W'(5);
                        6'd39: dec_alu_ctrl = ALUCTRL_W'(6);
                        6'd0:  begin dec_alu_ctrl = ALUCTRL_W'(7); dec_shift = 1'b1; rs_used = 1'b0; end
                        6'd2:  begin dec_alu_ctrl = ALUCTRL_W'(8); dec_shift = 1'b1; rs_used = 1'b0; end
                        6'd3:  begin dec_alu_ctrl = ALUCTRL_W'(9); dec_shift = 1'b1; rs_used = 1'b0; end
                        6'd8:  begin dec_jump = 1'b1; dec_reg_write = 1'b0; end
                        default: begin
                            dec_reg_write = 1'b0;
                            rs_used       = 1'b0;
                            rt_used       = 1'b0;
                            dec_illegal   = 1'b1;
                        end
                    endcase
                end
                6'd8, 6'd10, 6'd12, 6'd13, 6'd14: begin
                    dec_alu_src   = 1'b1;
                    dec_reg_write = 1'b1;
                    dec_dst       = id_rt;
                    rs_used       = 1'b1;
                    case (id_opcode)
                        6'd10:   dec_alu_ctrl = ALUCTRL_W'(4);
                        6'd12:   dec_alu_ctrl = ALUCTRL_W'(2);
                        6'd13:   dec_alu_ctrl = ALUCTRL_W'(3);
                        6'd14:   dec_alu_ctrl = ALUCTRL_W'(5);
                        default: dec_alu_ctrl = ALUCTRL_W'(0);
                    endcase
                end
                6'd35: begin
                    dec_alu_src    = 1'b1;
                    dec_mem_read   = 1'b1;
                    dec_mem_to_reg = 1'b1;
                    dec_reg_write  = 1'b1;
                    dec_dst        = id_rt;
                    rs_used        = 1'b1;
                end
                6'd43: begin
                    dec_alu_src   = 1'b1;
                    dec_mem_write = 1'b1;
                    rs_used       = 1'b1;
                    rt_used       = 1'b1;
                end
                6'd4: begin
                    dec_alu_ctrl = ALUCTRL_W'(1);
                    dec_branch   = 1'b1;
                    rs_used      = 1'b1;
                    rt_used      = 1'b1;
                end
                6'd2: dec_jump = 1'b1;
                6'd3: begin
                    dec_jump      = 1'b1;
                    dec_reg_write = 1'b1;
                    dec_dst       = REG_AW'(LINK_REG);
                end
                default: dec_illegal = 1'b1;
            endcase
            // r0 is hard-wired: never write it, and keep dst clean when nothing is written
            if (dec_dst == '0) dec_reg_write = 1'b0;
            if (!dec_reg_write) dec_dst = '0;
        end
    end

    assign idex_wr  = idex_valid_reg & idex_reg_write_reg & (idex_dst_reg != '0);
    assign exmem_wr = exmem_valid_reg & exmem_reg_write_reg & (exmem_dst_reg != '0);

`ifdef FORWARD_EN
    logic [REG_AW-1:0] idex_rs_reg, idex_rt_reg;
    logic              memwb_wr, ex_hit, load_use, jr_hazard;

    assign memwb_wr  = memwb_valid_reg & memwb_reg_write_reg & (memwb_dst_reg != '0);
    assign ex_hit    = (rs_used & (id_rs == idex_dst_reg)) | (rt_used & (id_rt == idex_dst_reg));
    assign load_use  = idex_wr & idex_mem_read_reg & ex_hit;
    // jr reads rs in ID, so it cannot use the EX bypass
    assign jr_hazard = dec_jump & (id_opcode == 6'd0) &
                       ((idex_wr & (id_rs == idex_dst_reg)) | (exmem_wr & (id_rs == exmem_dst_reg)));
    assign raw_stall = load_use | jr_hazard;

    // Remember EX source registers for the bypass comparators
    always_ff @(posedge clk) begin
        if (!rst_n || stall || ex_branch_taken || !id_valid) begin
            idex_rs_reg <= '0;
            idex_rt_reg <= '0;
        end else begin
            idex_rs_reg <= id_rs;
            idex_rt_reg <= id_rt;
        end
    end

    // Operand bypass select: EX/MEM result beats MEM/WB result
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (exmem_wr && exmem_dst_reg == idex_rs_reg)      fwd_a = 2'b10;
        else if (memwb_wr && memwb_dst_reg == idex_rs_reg) fwd_a = 2'b01;
        if (exmem_wr && exmem_dst_reg == idex_rt_reg)      fwd_b = 2'b10;
        else if (memwb_wr && memwb_dst_reg == idex_rt_reg) fwd_b = 2'b01;
    end
`else
    logic ex_hit, mem_hit;

    assign ex_hit    = (rs_used & (id_rs == idex_dst_reg)) | (rt_used & (id_rt == idex_dst_reg));
    assign mem_hit   = (rs_used & (id_rs == exmem_dst_reg)) | (rt_used & (id_rt == exmem_dst_reg));
    assign raw_stall = (idex_wr & ex_hit) | (exmem_wr & mem_hit);
    assign fwd_a     = 2'b00;
    assign fwd_b     = 2'b00;
`endif

    // A taken branch squashes the ID instruction, so it overrides stall and jump
    assign stall      = raw_stall & ~ex_branch_taken;
    assign id_jump    = dec_jump & ~ex_branch_taken;
    assign flush      = ex_branch_taken | (id_jump & ~stall);
    assign id_illegal = dec_illegal;

    // ID/EX: bubble on reset, stall or branch squash, otherwise the decoded word
    always_ff @(posedge clk) begin
        if (!rst_n || stall || ex_branch_taken) begin
            idex_valid_reg      <= 1'b0;
            idex_alu_ctrl_reg   <= '0;
            idex_alu_src_reg    <= 1'b0;
            idex_shift_reg      <= 1'b0;
            idex_branch_reg     <= 1'b0;
            idex_mem_read_reg   <= 1'b0;
            idex_mem_write_reg  <= 1'b0;
            idex_reg_write_reg  <= 1'b0;
            idex_mem_to_reg_reg <= 1'b0;
            idex_dst_reg        <= '0;
        end else begin
            idex_valid_reg      <= id_valid;
            idex_alu_ctrl_reg   <= dec_alu_ctrl;
            idex_alu_src_reg    <= dec_alu_src;
            idex_shift_reg      <= dec_shift;
            idex_branch_reg     <= dec_branch;
            idex_mem_read_reg   <= dec_mem_read;
            idex_mem_write_reg  <= dec_mem_write;
            idex_reg_write_reg  <= dec_reg_write;
            idex_mem_to_reg_reg <= dec_mem_to_reg;
            idex_dst_reg        <= dec_dst;
        end
    end

    // EX/MEM and MEM/WB advance every cycle; reset turns both into bubbles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exmem_valid_reg      <= 1'b0;
            exmem_mem_read_reg   <= 1'b0;
            exmem_mem_write_reg  <= 1'b0;
            exmem_reg_write_reg  <= 1'b0;
            exmem_mem_to_reg_reg <= 1'b0;
            exmem_dst_reg        <= '0;
            memwb_valid_reg      <= 1'b0;
            memwb_reg_write_reg  <= 1'b0;
            memwb_mem_to_reg_reg <= 1'b0;
            memwb_dst_reg        <= '0;
        end else begin
            exmem_valid_reg      <= idex_valid_reg;
            exmem_mem_read_reg   <= idex_mem_read_reg;
            exmem_mem_write_reg  <= idex_mem_write_reg;
            exmem_reg_write_reg  <= idex_reg_write_reg;
            exmem_mem_to_reg_reg <= idex_mem_to_reg_reg;
            exmem_dst_reg        <= idex_dst_reg;
            memwb_valid_reg      <= exmem_valid_reg;
            memwb_reg_write_reg  <= exmem_reg_write_reg;
            memwb_mem_to_reg_reg <= exmem_mem_to_reg_reg;
            memwb_dst_reg        <= exmem_dst_reg;
        end
    end

    assign ex_alu_ctrl   = idex_alu_ctrl_reg;
    assign ex_alu_src    = idex_alu_src_reg;
    assign ex_shift      = idex_shift_reg;
    assign ex_branch     = idex_branch_reg;
    assign mem_read      = exmem_mem_read_reg;
    assign mem_write     = exmem_mem_write_reg;
    assign wb_reg_write  = memwb_valid_reg & memwb_reg_write_reg;
    assign wb_mem_to_reg = memwb_mem_to_reg_reg;
    assign wb_dst        = memwb_dst_reg;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Testbench for pipe_ctrl_unit: scoreboard of per-stage controls plus
// directed hazard/flush/forwarding checks. Honours FORWARD_EN if defined.
`timescale 1ns/1ps
module tb_pipe_ctrl_unit;

`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    // Extra RAW stall cycles when no bypass network exists
    localparam int SUB_EXTRA = FWD ? 0 : 2;
    localparam int LU_EXTRA  = FWD ? 0 : 1;

    logic       clk = 1'b0;
    logic       rst_n, id_valid, ex_branch_taken;
    logic [5:0] id_opcode, id_func;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       stall, flush, id_jump, id_illegal;
    logic [3:0] ex_alu_ctrl;
    logic       ex_alu_src, ex_shift, ex_branch, mem_read, mem_write;
    logic       wb_reg_write, wb_mem_to_reg;
    logic [4:0] wb_dst;
    logic [1:0] fwd_a, fwd_b;

    always #5 clk = ~clk;

    pipe_ctrl_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_func(id_func),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_branch_taken(ex_branch_taken),
        .stall(stall), .flush(flush), .id_jump(id_jump), .id_illegal(id_illegal),
        .ex_alu_ctrl(ex_alu_ctrl), .ex_alu_src(ex_alu_src), .ex_shift(ex_shift),
        .ex_branch(ex_branch), .mem_read(mem_read), .mem_write(mem_write),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    typedef struct {
        int         due;
        logic [3:0] alu;
        logic       alu_src, shift, branch, mem_read, mem_write, reg_write, mem_to_reg;
        logic [4:0] dst;
    } exp_t;

    exp_t ex_q[$], mem_q[$], wb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic exp_t bubble_ctl();
        exp_t e;
        e = '{due: 0, alu: 4'd0, alu_src: 1'b0, shift: 1'b0, branch: 1'b0, mem_read: 1'b0,
              mem_write: 1'b0, reg_write: 1'b0, mem_to_reg: 1'b0, dst: 5'd0};
        return e;
    endfunction

    // Reference decode table for the expected stage controls
    function automatic exp_t ref_ctl(input logic [5:0] op, input logic [5:0] fn,
                                     input logic [4:0] rt, input logic [4:0] rd);
        exp_t e;
        e = bubble_ctl();
        case (op)
            6'd0: begin
                e.reg_write = 1'b1;
                e.dst       = rd;
                case (fn)
                    6'd32: e.alu = 4'd0;
                    6'd34: e.alu = 4'd1;
                    6'd36: e.alu = 4'd2;
                    6'd37: e.alu = 4'd3;
                    6'd42: e.alu = 4'd4;
                    6'd38: e.alu = 4'd5;
                    6'd39: e.alu = 4'd6;
                    6'd0:  begin e.alu = 4'd7; e.shift = 1'b1; end
                    6'd2:  begin e.alu = 4'd8; e.shift = 1'b1; end
                    6'd3:  begin e.alu = 4'd9; e.shift = 1'b1; end
                    6'd8:  e.reg_write = 1'b0;
                    default: e = bubble_ctl();
                endcase
            end
            6'd8:  begin e.alu_src = 1'b1; e.reg_write = 1'b1; e.dst = rt; e.alu = 4'd0; end
            6'd10: begin e.alu_src = 1'b1; e.reg_write = 1'b1; e.dst = rt; e.alu = 4'd4; end
            6'd12: begin e.alu_src = 1'b1; e.reg_write = 1'b1; e.dst = rt; e.alu = 4'd2; end
            6'd13: begin e.alu_src = 1'b1; e.reg_write = 1'b1; e.dst = rt; e.alu = 4'd3; end
            6'd14: begin e.alu_src = 1'b1; e.reg_write = 1'b1; e.dst = rt; e.alu = 4'd5; end
            6'd35: begin e.alu_src = 1'b1; e.mem_read = 1'b1; e.mem_to_reg = 1'b1;
                         e.reg_write = 1'b1; e.dst = rt; end
            6'd43: begin e.alu_src = 1'b1; e.mem_write = 1'b1; end
            6'd4:  begin e.alu = 4'd1; e.branch = 1'b1; end
            6'd3:  begin e.reg_write = 1'b1; e.dst = 5'd31; end
            default: ;
        endcase
        if (e.dst == 5'd0) e.reg_write = 1'b0;
        if (!e.reg_write) e.dst = 5'd0;
        return e;
    endfunction

    // Scoreboard: compare each stage against the entry due this cycle
    always @(negedge clk) begin
        if (ex_q.size() > 0 && ex_q[0].due == cyc) begin
            mon_e = ex_q.pop_front();
            check_value("ex_ctl", {ex_alu_ctrl, ex_alu_src, ex_shift, ex_branch},
                        {mon_e.alu, mon_e.alu_src, mon_e.shift, mon_e.branch});
        end
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            mon_e = mem_q.pop_front();
            check_value("mem_ctl", {mem_read, mem_write}, {mon_e.mem_read, mon_e.mem_write});
        end
        if (wb_q.size() > 0 && wb_q[0].due == cyc) begin
            mon_e = wb_q.pop_front();
            check_value("wb_ctl", {wb_reg_write, wb_mem_to_reg, wb_dst},
                        {mon_e.reg_write, mon_e.mem_to_reg, mon_e.dst});
        end
    end

    // Present one ID slot for one cycle, check ID outputs, queue what enters ID/EX
    task automatic issue(input string name, input bit valid, input logic [5:0] op,
                         input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input bit bt, input bit exp_stall,
                         input bit exp_flush, input bit exp_jump, input bit exp_illegal);
        exp_t e;
        id_valid = valid; id_opcode = op; id_func = fn;
        id_rs = rs; id_rt = rt; id_rd = rd; ex_branch_taken = bt;
        @(negedge clk);
        check_value({name, " stall"}, stall, exp_stall);
        check_value({name, " flush"}, flush, exp_flush);
        check_value({name, " id_jump"}, id_jump, exp_jump);
        check_value({name, " id_illegal"}, id_illegal, exp_illegal);
        if (valid && !exp_stall && !bt) e = ref_ctl(op, fn, rt, rd);
        else e = bubble_ctl();
        e.due = cyc + 1; ex_q.push_back(e);
        e.due = cyc + 2; mem_q.push_back(e);
        e.due = cyc + 3; wb_q.push_back(e);
        $display("cyc=%0d %-10s stall=%0b flush=%0b jump=%0b illegal=%0b", cyc, name,
                 stall, flush, id_jump, id_illegal);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue("idle", 1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; id_valid = 1'b0; id_opcode = '0; id_func = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; ex_branch_taken = 1'b0;
        ex_q.delete(); mem_q.delete(); wb_q.delete();
        @(posedge clk); #1;
        @(negedge clk);
        check_value("reset_outputs",
                    {stall, flush, id_jump, id_illegal, ex_alu_ctrl, ex_alu_src, ex_shift, ex_branch,
                     mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_dst, fwd_a, fwd_b}, 32'd0);
        $display("cyc=%0d reset applied", cyc);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_opcode = '0; id_func = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; ex_branch_taken = 1'b0;
        @(posedge clk); #1;
        do_reset();
        idle(3);

        // add r3,r1,r2 ; sub r4,r3,r1
        issue("add", 1, 6'd0, 6'd32, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0);
        for (int i = 0; i < SUB_EXTRA; i++)
            issue("sub", 1, 6'd0, 6'd34, 5'd3, 5'd1, 5'd4, 0, 1, 0, 0, 0);
        issue("sub", 1, 6'd0, 6'd34, 5'd3, 5'd1, 5'd4, 0, 0, 0, 0, 0);
        check_value("sub fwd_a", fwd_a, FWD ? 2'b10 : 2'b00);
        check_value("sub fwd_b", fwd_b, 2'b00);
        idle(3);

        // lw r5 ; add r6,r5,r0 (load-use)
        issue("lw", 1, 6'd35, 6'd0, 5'd1, 5'd5, 5'd0, 0, 0, 0, 0, 0);
        issue("add_lu", 1, 6'd0, 6'd32, 5'd5, 5'd0, 5'd6, 0, 1, 0, 0, 0);
        for (int i = 0; i < LU_EXTRA; i++)
            issue("add_lu", 1, 6'd0, 6'd32, 5'd5, 5'd0, 5'd6, 0, 1, 0, 0, 0);
        issue("add_lu", 1, 6'd0, 6'd32, 5'd5, 5'd0, 5'd6, 0, 0, 0, 0, 0);
        check_value("lu fwd_a", fwd_a, FWD ? 2'b01 : 2'b00);
        idle(3);

        // independent mix: sll, sw, xori, slt, add to r0
        issue("sll", 1, 6'd0, 6'd0, 5'd0, 5'd1, 5'd8, 0, 0, 0, 0, 0);
        issue("sw", 1, 6'd43, 6'd0, 5'd1, 5'd2, 5'd0, 0, 0, 0, 0, 0);
        issue("xori", 1, 6'd14, 6'd0, 5'd1, 5'd9, 5'd0, 0, 0, 0, 0, 0);
        issue("slt", 1, 6'd0, 6'd42, 5'd1, 5'd2, 5'd10, 0, 0, 0, 0, 0);
        issue("add_r0", 1, 6'd0, 6'd32, 5'd1, 5'd2, 5'd0, 0, 0, 0, 0, 0);
        idle(3);

        // add r7 ; jr r7 stalls while EX and then MEM write r7
        issue("add_r7", 1, 6'd0, 6'd32, 5'd1, 5'd2, 5'd7, 0, 0, 0, 0, 0);
        issue("jr", 1, 6'd0, 6'd8, 5'd7, 5'd0, 5'd0, 0, 1, 0, 1, 0);
        issue("jr", 1, 6'd0, 6'd8, 5'd7, 5'd0, 5'd0, 0, 1, 0, 1, 0);
        issue("jr", 1, 6'd0, 6'd8, 5'd7, 5'd0, 5'd0, 0, 0, 1, 1, 0);
        idle(3);

        // beq taken while ID holds jal: branch wins, jal squashed
        issue("beq", 1, 6'd4, 6'd0, 5'd1, 5'd2, 5'd0, 0, 0, 0, 0, 0);
        issue("jal_sq", 1, 6'd3, 6'd0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 0);
        idle(3);

        // jal alone
        issue("jal", 1, 6'd3, 6'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0);
        idle(3);

        // illegal opcode and illegal R-type func
        issue("op63", 1, 6'd63, 6'd0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1);
        issue("fn1", 1, 6'd0, 6'd1, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1);
        idle(3);

        // reset asserted mid load-use stall
        issue("lw_r", 1, 6'd35, 6'd0, 5'd1, 5'd5, 5'd0, 0, 0, 0, 0, 0);
        id_valid = 1'b1; id_opcode = 6'd0; id_func = 6'd32;
        id_rs = 5'd5; id_rt = 5'd0; id_rd = 5'd6; rst_n = 1'b0;
        ex_q.delete(); mem_q.delete(); wb_q.delete();
        @(negedge clk);
        check_value("rst_midstall stall", stall, 1'b1);
        $display("cyc=%0d reset during stall", cyc);
        @(posedge clk); #1;
        check_value("rst_midstall regs",
                    {stall, ex_alu_ctrl, ex_alu_src, ex_shift, ex_branch, mem_read, mem_write,
                     wb_reg_write, wb_mem_to_reg, wb_dst, fwd_a, fwd_b}, 32'd0);
        rst_n = 1'b1;
        idle(3);

        repeat (4) @(posedge clk);
        #1;
        check_value("scoreboard_empty", ex_q.size() + mem_q.size() + wb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined MIPS control unit with hazard handling. Decodes opcode/func in ID, registers the control word through the ID/EX, EX/MEM and MEM/WB stages, and drives stage-local controls to the datapath. Load-use and RAW hazards produce stall and bubble insertion, and taken branches and jumps produce flushes. Sits between the IF/ID register and the datapath, and replaces the single-cycle combinational decoder.

## Interface
- ALUCTRL_W, 4: ALU control width; must be ≥4.
- REG_AW, 5: register address width.
- LINK_REG, 31: destination register for jal.
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_opcode, id_func  in  6 each  instruction fields.
- id_rs, id_rt, id_rd  in  REG_AW each  register fields.
- ex_branch_taken  in  1  beq in EX resolved taken.
- stall  out  1  hold PC and IF/ID this cycle.
- flush  out  1  discard IF/ID contents at next edge.
- id_jump  out  1  ID holds j/jal/jr; PC takes the jump target.
- id_illegal  out  1  valid instruction with unknown opcode/func.
- ex_alu_ctrl  out  ALUCTRL_W  ALU operation for the EX instruction.
- ex_alu_src, ex_shift, ex_branch  out  1 each  EX controls.
- mem_read, mem_write  out  1 each  MEM-stage controls.
- wb_reg_write, wb_mem_to_reg  out  1 each  WB-stage controls.
- wb_dst  out  REG_AW  WB write address.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.

## Operation

**Decode**
- R-type (opcode 0) maps func to ALU control:
  - 32 → 0 (add), 34 → 1 (sub), 36 → 2 (and), 37 → 3 (or), 42 → 4 (slt), 38 → 5 (xor), 39 → 6 (nor).
  - 0 → 7 (sll), 2 → 8 (srl), 3 → 9 (sra). Shift is set only for these three funcs, and only when opcode = 0.
  - 8 is jr: jump, no register write.
  - Destination is rd; RegWrite = 1 except for jr.
- I-type: ALUSrc = 1 and destination is rt.
  - 8 addi → 0, 10 slti → 4, 12 andi → 2, 13 ori → 3, 14 xori → 5.
  - 35 lw: alu 0, MemRead = 1, MemToReg = 1, RegWrite = 1.
  - 43 sw: alu 0, MemWrite = 1, no RegWrite.
- 4 beq: alu 1, Branch = 1.
- 2 j: jump only. 3 jal: jump, RegWrite = 1, destination LINK_REG.
- Any other opcode/func: all controls 0 and id_illegal = 1.
- A write to register 0 is cleared to RegWrite = 0.

**Source usage**
- rs is used by R-type (except sll/srl/sra), I-type, lw, sw, beq and jr.
- rt is used by R-type, sw and beq.

**Pipeline**
- Each stage register holds a valid bit plus its remaining controls.
- A bubble is valid = 0 with all controls 0.

**Hazards**
- Load-use: the EX instruction is lw, its dst ≠ 0, and dst matches a used ID source. Then stall = 1 for one cycle and a bubble enters ID/EX.
- jr additionally stalls while EX or MEM writes its rs, because jr reads rs in ID.

**Flush**
- ex_branch_taken: flush = 1. A bubble enters ID/EX and stall is forced to 0, so the wrong-path ID instruction is discarded.
- id_jump with no stall: flush = 1. The jump itself advances into ID/EX.
- Simultaneous ex_branch_taken and id_jump: the branch wins, and id_jump is masked to 0.

**Forwarding**
- fwd_a compares the EX rs against the EX/MEM dst, then the MEM/WB dst. EX/MEM has priority; a match requires RegWrite and dst ≠ 0.
- fwd_b does the same for rt.

## Timing
- Reset: every stage register becomes a bubble. All registered outputs are 0; stall, flush, id_jump, id_illegal and fwd_* are 0 while id_valid = 0.
- ID → EX controls: 1 cycle. → MEM: 2 cycles. → WB: 3 cycles.
- stall, flush, id_jump and fwd_* are combinational from the current-cycle inputs and stage registers.
- The register file writes in WB and bypasses internally, so WB is never a hazard source.
- While stall = 1, the ID inputs are held by IF/ID and are re-evaluated each cycle.
- Reset asserted mid-stall or mid-flush: the pipeline is a bubble on the next cycle, and no stale controls remain.

## Configuration
- FORWARD_EN defined: forwarding logic is present, and only load-use and jr hazards stall.
- FORWARD_EN undefined:
  - fwd_a/fwd_b are tied to 00.
  - stall = 1 while any valid EX or MEM instruction with RegWrite, dst ≠ 0, has a dst matching a used ID source.
  - This can give up to 2 stall cycles per dependency.

## Test plan
- Reset, then id_valid = 0 → every output 0; after reset release, a bubble shows in all stages for 3 cycles.
- add r3,r1,r2 then sub r4,r3,r1 back-to-back:
  - With FORWARD_EN: fwd_a = 10 on the sub's EX cycle, no stall.
  - Without FORWARD_EN: stall = 1 for 2 cycles.
- lw r5 then add r6,r5,r0 → stall = 1 for exactly 1 cycle; ex_alu_ctrl reads 0 with valid = 0 in the bubble; afterwards fwd_a = 01.
- beq taken (ex_branch_taken = 1) while ID holds jal → flush = 1, id_jump = 0, and the ID/EX bubble means no LINK_REG write appears 3 cycles later.
- jal alone → id_jump = 1, flush = 1; wb_reg_write = 1 with wb_dst = 31 three cycles later.
- Opcode 6'd63 with id_valid = 1 → id_illegal = 1; the instruction flows as a no-op with no write or memory access.
